// File: rtl/difftest_commit_queue_pkg.sv
// Shared definitions for the Difftest commit queue slice.
//   DEFAULT_XLEN   default PC/data width
//   COMMIT_W       retire/commit slots per cycle
//   DIFF_VALID_W   width of the commit_valid vector handed to the DPI wrapper
//   DIFF_NUM_W     width of the commit_num field handed to the DPI wrapper
//   commit_entry_t one buffered instruction (pc + writeback data)
//   popcount2      number of set bits in a 2-bit valid vector
package difftest_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam int unsigned COMMIT_W     = 2;
  localparam int unsigned DIFF_VALID_W = 4;
  localparam int unsigned DIFF_NUM_W   = 8;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] data;
  } commit_entry_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/difftest_commit_queue_if.sv
// Retire-side and commit-side signal bundle of the Difftest commit queue.
//   Retire side : rob_valid, rob_pc0/1, rob_data0/1 (from ROB), rob_ready (to ROB)
//   Commit side : out_ready (from DPI wrapper), commit_num, commit_valid,
//                 commit_pc1/2, commit_data1/2 (to DPI wrapper)
//   master : the environment (ROB + DPI wrapper)
//   slave  : the commit queue
interface difftest_commit_queue_if
  import difftest_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN
);
  logic [COMMIT_W-1:0]     rob_valid;
  logic [XLEN-1:0]         rob_pc0;
  logic [XLEN-1:0]         rob_pc1;
  logic [XLEN-1:0]         rob_data0;
  logic [XLEN-1:0]         rob_data1;
  logic                    rob_ready;
  logic                    out_ready;
  logic [DIFF_NUM_W-1:0]   commit_num;
  logic [DIFF_VALID_W-1:0] commit_valid;
  logic [XLEN-1:0]         commit_pc1;
  logic [XLEN-1:0]         commit_pc2;
  logic [XLEN-1:0]         commit_data1;
  logic [XLEN-1:0]         commit_data2;

  modport master (
    output rob_valid, rob_pc0, rob_pc1, rob_data0, rob_data1, out_ready,
    input  rob_ready, commit_num, commit_valid,
           commit_pc1, commit_pc2, commit_data1, commit_data2
  );

  modport slave (
    input  rob_valid, rob_pc0, rob_pc1, rob_data0, rob_data1, out_ready,
    output rob_ready, commit_num, commit_valid,
           commit_pc1, commit_pc2, commit_data1, commit_data2
  );
endinterface

// File: rtl/difftest_commit_queue_fifo.sv
// commit_fifo_2w2r: circular buffer accepting 0..2 entries and releasing
// 0..2 entries per cycle.
//   clock, reset         clock / synchronous active-high reset
//   wr_num               entries to write this cycle (caller guarantees room)
//   wr_data0, wr_data1   entries written in that order at the tail
//   rd_num               entries to pop this cycle (caller guarantees <= count)
//   rd_data0, rd_data1   the two oldest entries (valid only up to count)
//   count                occupancy before this cycle's write/read
import difftest_pkg::*;

module commit_fifo_2w2r #(
  parameter int unsigned DEPTH   = 8,
  parameter type         entry_t = commit_entry_t
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 wr_num,
  input  entry_t                     wr_data0,
  input  entry_t                     wr_data1,
  input  logic [1:0]                 rd_num,
  output entry_t                     rd_data0,
  output entry_t                     rd_data1,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_num);
      rd_ptr <= rd_ptr + PW'(rd_num);
      count  <= count + (PW+1)'(wr_num) - (PW+1)'(rd_num);
    end
  end

  // Storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (wr_num != 2'd0) mem[wr_ptr]          <= wr_data0;
      if (wr_num == 2'd2) mem[wr_ptr + PW'(1)] <= wr_data1;
    end
  end

  assign rd_data0 = mem[rd_ptr];
  assign rd_data1 = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/difftest_commit_queue.sv
// difftest_commit_queue: captures up to two retired instructions per cycle
// from the ROB, compacts them into program order, buffers them and replays
// at most two per cycle as a registered commit bundle to the Difftest DPI
// wrapper. Also counts retired instructions and watches for pipeline hangs.
//   clock, reset   clock / synchronous active-high reset
//   bus            retire and commit handshake (slave side)
//   retire_count   total instructions popped since reset (wraps at 2^64)
//   hang_timeout   sticky; no accepted retire for TIMEOUT cycles
//   overflow       sticky; a retire arrived while rob_ready was low
import difftest_pkg::*;

module difftest_commit_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned XLEN    = DEFAULT_XLEN,
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic                   clock,
  input  logic                   reset,
  difftest_commit_queue_if.slave bus,
  output logic [63:0]            retire_count,
  output logic                   hang_timeout,
  output logic                   overflow
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } entry_t;

  logic [CW-1:0] count;
  logic          rob_ready_i;
  logic          accept;
  logic [1:0]    wr_num;
  logic [1:0]    rd_num;
  entry_t        slot0, slot1;
  entry_t        wr_data0, wr_data1;
  entry_t        rd_data0, rd_data1;
  logic [31:0]   idle_cnt;
  logic [31:0]   idle_next;

  assign rob_ready_i   = (CW'(DEPTH) - count) >= CW'(2);
  assign bus.rob_ready = rob_ready_i;

  assign slot0 = '{pc: bus.rob_pc0, data: bus.rob_data0};
  assign slot1 = '{pc: bus.rob_pc1, data: bus.rob_data1};

  // Compaction: the oldest valid slot always lands in the first free entry,
  // so a lone slot1 retire occupies the same position a lone slot0 would.
  always_comb begin
    accept   = rob_ready_i && (bus.rob_valid != '0);
    wr_num   = accept ? popcount2(bus.rob_valid) : 2'd0;
    wr_data0 = bus.rob_valid[0] ? slot0 : slot1;
    wr_data1 = slot1;
  end

  // Pops are sized from the pre-enqueue count, so same-cycle retires are
  // never bypassed to the output.
  always_comb begin
    rd_num = 2'd0;
    if (bus.out_ready) begin
      rd_num = (count >= CW'(2)) ? 2'd2 : count[1:0];
    end
  end

  commit_fifo_2w2r #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_num   (wr_num),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .rd_num   (rd_num),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1),
    .count    (count)
  );

  always_comb begin
    idle_next = idle_cnt;
    if (accept) begin
      idle_next = '0;
    end else if (idle_cnt < 32'(TIMEOUT)) begin
      idle_next = idle_cnt + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.commit_num   <= '0;
      bus.commit_valid <= '0;
      bus.commit_pc1   <= '0;
      bus.commit_pc2   <= '0;
      bus.commit_data1 <= '0;
      bus.commit_data2 <= '0;
      retire_count     <= '0;
      idle_cnt         <= '0;
      hang_timeout     <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      if (bus.out_ready) begin
        bus.commit_num   <= DIFF_NUM_W'(rd_num);
        bus.commit_valid <= {2'b00, rd_num == 2'd2, rd_num != 2'd0};
        bus.commit_pc1   <= (rd_num != 2'd0) ? rd_data0.pc   : '0;
        bus.commit_data1 <= (rd_num != 2'd0) ? rd_data0.data : '0;
        bus.commit_pc2   <= (rd_num == 2'd2) ? rd_data1.pc   : '0;
        bus.commit_data2 <= (rd_num == 2'd2) ? rd_data1.data : '0;
      end else begin
        bus.commit_num   <= '0;
        bus.commit_valid <= '0;
      end
      retire_count <= retire_count + 64'(rd_num);
      idle_cnt     <= idle_next;
      if (idle_next == 32'(TIMEOUT)) hang_timeout <= 1'b1;
      if (bus.rob_valid != '0 && !rob_ready_i) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_difftest_commit_queue.sv
module tb_difftest_commit_queue;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 20;

  logic        clock;
  logic        reset;
  logic [63:0] retire_count;
  logic        hang_timeout;
  logic        overflow;

  difftest_commit_queue_if #(.XLEN(32)) bus ();

  difftest_commit_queue #(
    .DEPTH   (DEPTH),
    .XLEN    (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .retire_count (retire_count),
    .hang_timeout (hang_timeout),
    .overflow     (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  // Reference model: a plain queue of pending instructions plus expected outputs.
  ent_t        q[$];
  int          e_num;
  logic [31:0] e_pc1, e_pc2, e_d1, e_d2;
  logic [63:0] e_ret;
  logic        e_hang, e_ovf;
  int          since_retire;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] ev;
    ev = {2'b00, e_num == 2, e_num >= 1};
    chk("commit_num",   64'(bus.commit_num),   64'(e_num));
    chk("commit_valid", 64'(bus.commit_valid), 64'(ev));
    chk("commit_pc1",   64'(bus.commit_pc1),   64'(e_pc1));
    chk("commit_pc2",   64'(bus.commit_pc2),   64'(e_pc2));
    chk("commit_data1", 64'(bus.commit_data1), 64'(e_d1));
    chk("commit_data2", 64'(bus.commit_data2), 64'(e_d2));
    chk("retire_count", retire_count,          e_ret);
    chk("hang_timeout", 64'(hang_timeout),     64'(e_hang));
    chk("overflow",     64'(overflow),         64'(e_ovf));
    chk("rob_ready",    64'(bus.rob_ready),    64'((DEPTH - q.size()) >= 2));
  endtask

  // One clock: drive inputs, advance the model, clock the DUT, compare.
  task automatic step(input logic rst, input logic [1:0] v,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic ordy);
    int   m;
    bit   ready, acc;
    ent_t a, b;
    reset         = rst;
    bus.rob_valid = v;
    bus.rob_pc0   = p0;
    bus.rob_pc1   = p1;
    bus.rob_data0 = d0;
    bus.rob_data1 = d1;
    bus.out_ready = ordy;
    if (rst) begin
      q.delete();
      e_num = 0; e_pc1 = '0; e_pc2 = '0; e_d1 = '0; e_d2 = '0;
      e_ret = '0; e_hang = 1'b0; e_ovf = 1'b0; since_retire = 0;
    end else begin
      ready = (DEPTH - q.size()) >= 2;
      acc   = ready && (v != 2'b00);
      m     = ordy ? ((q.size() < 2) ? q.size() : 2) : 0;
      if (ordy) begin
        e_num = m;
        e_pc1 = '0; e_d1 = '0; e_pc2 = '0; e_d2 = '0;
        if (m >= 1) begin a = q.pop_front(); e_pc1 = a.pc; e_d1 = a.data; end
        if (m == 2) begin b = q.pop_front(); e_pc2 = b.pc; e_d2 = b.data; end
      end else begin
        e_num = 0;
      end
      if (v != 2'b00 && !ready) e_ovf = 1'b1;
      if (acc) begin
        if (v[0]) q.push_back('{pc: p0, data: d0});
        if (v[1]) q.push_back('{pc: p1, data: d1});
      end
      e_ret        = e_ret + 64'(m);
      since_retire = acc ? 0 : since_retire + 1;
      if (since_retire >= TIMEOUT) e_hang = 1'b1;
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 2'b00, '0, '0, '0, '0, ordy);
  endtask

  initial begin
    logic [1:0]  rv;
    logic [63:0] ret_before;
    q.delete();

    // Reset, then idle
    step(1'b1, 2'b00, '0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b1);
    chk("idle_num0", 64'(bus.commit_num), 64'd0);

    // Dual retire; bundle appears two edges later
    step(1'b0, 2'b11, 32'h8000_0000, 32'h8000_0004, 32'h11, 32'h22, 1'b1);
    chk("dual_lat1_num", 64'(bus.commit_num), 64'd0);
    idle(1'b1);
    chk("dual_num",   64'(bus.commit_num),   64'd2);
    chk("dual_valid", 64'(bus.commit_valid), 64'h3);
    chk("dual_pc1",   64'(bus.commit_pc1),   64'h8000_0000);
    chk("dual_pc2",   64'(bus.commit_pc2),   64'h8000_0004);

    // Lone slot1 retire is compacted into the first output slot
    step(1'b0, 2'b10, 32'hdead_beef, 32'h8000_0010, 32'h99, 32'h55, 1'b1);
    idle(1'b1);
    chk("slot1_num",   64'(bus.commit_num),   64'd1);
    chk("slot1_valid", 64'(bus.commit_valid), 64'h1);
    chk("slot1_pc1",   64'(bus.commit_pc1),   64'h8000_0010);
    chk("slot1_data1", 64'(bus.commit_data1), 64'h55);
    chk("slot1_pc2",   64'(bus.commit_pc2),   64'h0);

    // Fill with output stalled, overflow, then drain in order
    ret_before = e_ret;
    for (int i = 0; i < 4; i++)
      step(1'b0, 2'b11, 32'h100 + 32'(16*i), 32'h104 + 32'(16*i),
           32'(i), 32'(i + 100), 1'b0);
    chk("full_rob_ready", 64'(bus.rob_ready), 64'd0);
    step(1'b0, 2'b01, 32'hbad0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("full_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drain_retired", retire_count - ret_before, 64'd8);
    chk("drain_last_pc2", 64'(bus.commit_pc2), 64'h134);
    idle(1'b1);
    chk("drain_empty_num", 64'(bus.commit_num), 64'd0);

    // Watchdog: exactly TIMEOUT cycles after the last accepted retire
    step(1'b1, 2'b00, '0, '0, '0, '0, 1'b1);
    step(1'b0, 2'b01, 32'h200, '0, 32'h7, '0, 1'b1);
    for (int i = 0; i < TIMEOUT - 1; i++) idle(1'b1);
    chk("hang_before", 64'(hang_timeout), 64'd0);
    idle(1'b1);
    chk("hang_at", 64'(hang_timeout), 64'd1);
    step(1'b0, 2'b11, 32'h300, 32'h304, '0, '0, 1'b1);
    chk("hang_sticky", 64'(hang_timeout), 64'd1);

    // Reset mid-drain with five entries still buffered
    step(1'b1, 2'b00, '0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 2'b11, 32'h400 + 32'(8*i), 32'h404 + 32'(8*i), '1, '1, 1'b0);
    step(1'b0, 2'b01, 32'h418, '0, '1, '0, 1'b0);
    idle(1'b1);
    step(1'b1, 2'b00, '0, '0, '0, '0, 1'b1);
    chk("rst_mid_ready", 64'(bus.rob_ready), 64'd1);
    chk("rst_mid_pc1",   64'(bus.commit_pc1), 64'd0);
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("rst_mid_stale", 64'(bus.commit_num), 64'd0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      rv = 2'($urandom_range(0, 3));
      if ((DEPTH - q.size()) < 2 && $urandom_range(0, 7) != 0) rv = 2'b00;
      step(($urandom_range(0, 99) == 0), rv, $urandom, $urandom, $urandom, $urandom,
           1'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
